// File: rtl/proc_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: owns the PC, sticky halt/error status,
// the memory-stall timeout and saturating cycle/instruction counters.
module proc_seq #(
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                CNT_W    = 32,
    parameter int                TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              dec_err,
    input  logic              is_halt,
    input  logic              is_mem,
    input  logic              wb_en_req,
    input  logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] pc,
    output logic              imem_req,
    output logic              ir_load,
    output logic              dmem_req,
    output logic              rf_we,
    output logic [2:0]        state,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    // Wide enough to hold TIMEOUT itself; TIMEOUT=0 still gets a 1-bit counter.
    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6,
        ST_ILL    = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_pc;
    logic                r_err;
    logic                r_halted;
    logic [CNT_W-1:0]    r_cycle;
    logic [CNT_W-1:0]    r_instr;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_inc;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_wb_ok;
    logic                w_active;

    assign w_wait_inc = r_wait + WAIT_W'(1);
    assign w_waiting  = ((r_state == ST_FETCH) && !imem_ready) ||
                        ((r_state == ST_MEM)   && !dmem_ready);
    // Ready in the same cycle as the limit wins: timeout only fires while still waiting.
    assign w_timeout  = (TIMEOUT != 0) && w_waiting && (w_wait_inc == WAIT_W'(TIMEOUT));
    assign w_wb_ok    = (r_state == ST_WB) && !pc_next[0];
    assign w_active   = (r_state != ST_HALT) && (r_state != ST_ERR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (imem_ready)     w_state_nxt = ST_DECODE;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_DECODE: begin
                if (dec_err)      w_state_nxt = ST_ERR;
                else if (is_halt) w_state_nxt = ST_HALT;
                else              w_state_nxt = ST_EXEC;
            end
            ST_EXEC:  w_state_nxt = is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ready)     w_state_nxt = ST_WB;
                else if (w_timeout) w_state_nxt = ST_ERR;
            end
            ST_WB:    w_state_nxt = pc_next[0] ? ST_ERR : ST_FETCH;
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_ERR:   w_state_nxt = ST_ERR;
            default:  w_state_nxt = ST_ERR;
        endcase
    end

    // Strobes are gated by rst so an in-flight access dies the moment reset asserts.
    always_comb begin
        imem_req = 1'b0;
        ir_load  = 1'b0;
        dmem_req = 1'b0;
        rf_we    = 1'b0;
        if (rst) begin
            imem_req = (r_state == ST_FETCH);
            ir_load  = (r_state == ST_FETCH) && imem_ready;
            dmem_req = (r_state == ST_MEM);
            rf_we    = w_wb_ok && wb_en_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_FETCH;
            r_pc     <= PC_RESET;
            r_err    <= 1'b0;
            r_halted <= 1'b0;
            r_cycle  <= '0;
            r_instr  <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == ST_ERR)  r_err    <= 1'b1;
            if (w_state_nxt == ST_HALT) r_halted <= 1'b1;
            if (w_wb_ok)                r_pc     <= pc_next;
            if (w_active && (r_cycle != '1)) r_cycle <= r_cycle + CNT_W'(1);
            if (w_wb_ok && (r_instr != '1))  r_instr <= r_instr + CNT_W'(1);
            r_wait <= w_waiting ? w_wait_inc : '0;
        end
    end

    assign pc        = r_pc;
    assign state     = r_state;
    assign halted    = r_halted;
    assign err       = r_err;
    assign cycle_cnt = r_cycle;
    assign instr_cnt = r_instr;

endmodule

// File: tb/tb_proc_seq.sv
// Directed bench for proc_seq (TIMEOUT=4, CNT_W=4): drivers queue one expected output
// vector per cycle, and a negedge monitor pops and compares it against the DUT.
module tb_proc_seq;

  localparam int EW = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ready, dmem_ready, dec_err, is_halt, is_mem, wb_en_req;
  logic [15:0] pc_next;
  logic [15:0] pc;
  logic        imem_req, ir_load, dmem_req, rf_we;
  logic [2:0]  state;
  logic        halted, err;
  logic [3:0]  cycle_cnt, instr_cnt;

  proc_seq #(
    .DATA_W   (16),
    .PC_RESET (16'h0000),
    .CNT_W    (4),
    .TIMEOUT  (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .dec_err    (dec_err),
    .is_halt    (is_halt),
    .is_mem     (is_mem),
    .wb_en_req  (wb_en_req),
    .pc_next    (pc_next),
    .pc         (pc),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .dmem_req   (dmem_req),
    .rf_we      (rf_we),
    .state      (state),
    .halted     (halted),
    .err        (err),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [EW-1:0] act;

  assign act = {state, pc, imem_req, ir_load, dmem_req, rf_we, halted, err, cycle_cnt, instr_cnt};

  always @(negedge clk) begin
    logic [EW-1:0] e;
    string         n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s got %h exp %h (state,pc,strobes,halted,err,cyc,ins)", n, act, e);
      end
    end
  end

  // expected-vector packing; counters saturate at 15
  function automatic logic [EW-1:0] pk(input logic [2:0] st, input logic [15:0] p,
                                       input logic [3:0] sb, input logic h, input logic e,
                                       input int cc, input int ic);
    logic [3:0] c4, i4;
    c4 = (cc > 15) ? 4'hF : cc[3:0];
    i4 = (ic > 15) ? 4'hF : ic[3:0];
    return {st, p, sb, h, e, c4, i4};
  endfunction

  // driver tasks
  int          e_cyc;
  int          e_ins;
  logic [15:0] e_pc;

  task automatic idle_in();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    dec_err    = 1'b0;
    is_halt    = 1'b0;
    is_mem     = 1'b0;
    wb_en_req  = 1'b0;
    pc_next    = 16'h0000;
  endtask

  task automatic cyc(input string n, input logic chk, input logic [EW-1:0] e);
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_in();
    cyc("rst_first", 1'b0, '0);
    cyc("rst_hold", 1'b1, pk(3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 0, 0));
    rst   = 1'b1;
    e_pc  = 16'h0000;
    e_cyc = 0;
    e_ins = 0;
  endtask

  task automatic run_instr(input int fw, input logic mem, input int mw, input logic wb,
                           input logic [15:0] pn);
    for (int i = 0; i < fw; i++) begin
      idle_in();
      cyc("fetch_wait", 1'b1, pk(3'd0, e_pc, 4'b1000, 1'b0, 1'b0, e_cyc, e_ins));
      e_cyc++;
    end
    idle_in();
    imem_ready = 1'b1;
    cyc("fetch", 1'b1, pk(3'd0, e_pc, 4'b1100, 1'b0, 1'b0, e_cyc, e_ins));
    e_cyc++;
    idle_in();
    cyc("decode", 1'b1, pk(3'd1, e_pc, 4'b0000, 1'b0, 1'b0, e_cyc, e_ins));
    e_cyc++;
    idle_in();
    is_mem = mem;
    cyc("exec", 1'b1, pk(3'd2, e_pc, 4'b0000, 1'b0, 1'b0, e_cyc, e_ins));
    e_cyc++;
    if (mem) begin
      for (int i = 0; i <= mw; i++) begin
        idle_in();
        dmem_ready = (i == mw);
        cyc("mem", 1'b1, pk(3'd3, e_pc, 4'b0010, 1'b0, 1'b0, e_cyc, e_ins));
        e_cyc++;
      end
    end
    idle_in();
    wb_en_req = wb;
    pc_next   = pn;
    cyc("wb", 1'b1, pk(3'd4, e_pc, {3'b000, wb & ~pn[0]}, 1'b0, 1'b0, e_cyc, e_ins));
    e_cyc++;
    if (!pn[0]) begin
      e_pc = pn;
      e_ins++;
    end
  endtask

  initial begin
    rst = 1'b0;
    idle_in();

    // reset and a single ALU instruction
    do_reset();
    run_instr(0, 1'b0, 0, 1'b1, 16'h0002);
    idle_in();
    cyc("alu_done", 1'b1, pk(3'd0, 16'h0002, 4'b1000, 1'b0, 1'b0, 4, 1));

    // load with three data-memory wait cycles: 8 cycles total
    do_reset();
    run_instr(0, 1'b1, 3, 1'b1, 16'h0004);
    idle_in();
    cyc("load_done", 1'b1, pk(3'd0, 16'h0004, 4'b1000, 1'b0, 1'b0, 8, 1));

    // fetch timeout after the 4th wait cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle_in();
      cyc("to_wait", 1'b1, pk(3'd0, 16'h0000, 4'b1000, 1'b0, 1'b0, i, 0));
    end
    for (int i = 0; i < 3; i++) begin
      idle_in();
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      wb_en_req  = 1'b1;
      cyc("to_err", 1'b1, pk(3'd6, 16'h0000, 4'b0000, 1'b0, 1'b1, 4, 0));
    end

    // ready in the 4th wait cycle is accepted
    do_reset();
    run_instr(3, 1'b0, 0, 1'b0, 16'h0006);
    idle_in();
    cyc("pulse_done", 1'b1, pk(3'd0, 16'h0006, 4'b1000, 1'b0, 1'b0, 7, 1));

    // dec_err has priority over is_halt
    do_reset();
    idle_in();
    imem_ready = 1'b1;
    cyc("pri_fetch", 1'b1, pk(3'd0, 16'h0000, 4'b1100, 1'b0, 1'b0, 0, 0));
    idle_in();
    dec_err = 1'b1;
    is_halt = 1'b1;
    cyc("pri_decode", 1'b1, pk(3'd1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1, 0));
    for (int i = 0; i < 2; i++) begin
      idle_in();
      imem_ready = 1'b1;
      wb_en_req  = 1'b1;
      cyc("pri_err", 1'b1, pk(3'd6, 16'h0000, 4'b0000, 1'b0, 1'b1, 2, 0));
    end

    // misaligned pc_next in WB
    do_reset();
    run_instr(0, 1'b0, 0, 1'b1, 16'h0003);
    for (int i = 0; i < 2; i++) begin
      idle_in();
      wb_en_req = 1'b1;
      pc_next   = 16'h0008;
      cyc("mis_err", 1'b1, pk(3'd6, 16'h0000, 4'b0000, 1'b0, 1'b1, 4, 0));
    end

    // halt freezes the cycle counter
    do_reset();
    idle_in();
    imem_ready = 1'b1;
    cyc("halt_fetch", 1'b1, pk(3'd0, 16'h0000, 4'b1100, 1'b0, 1'b0, 0, 0));
    idle_in();
    is_halt = 1'b1;
    cyc("halt_decode", 1'b1, pk(3'd1, 16'h0000, 4'b0000, 1'b0, 1'b0, 1, 0));
    for (int i = 0; i < 3; i++) begin
      idle_in();
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      cyc("halted", 1'b1, pk(3'd5, 16'h0000, 4'b0000, 1'b1, 1'b0, 2, 0));
    end

    // counter saturation over 20 instructions
    do_reset();
    for (int k = 0; k < 20; k++) begin
      run_instr(0, 1'b0, 0, 1'b1, 16'(2 * (k + 1)));
    end
    idle_in();
    imem_ready = 1'b1;
    cyc("sat_done", 1'b1, pk(3'd0, 16'd40, 4'b1100, 1'b0, 1'b0, 15, 15));

    // reset asserted mid-MEM stall
    idle_in();
    cyc("rm_decode", 1'b1, pk(3'd1, 16'd40, 4'b0000, 1'b0, 1'b0, 15, 15));
    idle_in();
    is_mem = 1'b1;
    cyc("rm_exec", 1'b1, pk(3'd2, 16'd40, 4'b0000, 1'b0, 1'b0, 15, 15));
    idle_in();
    cyc("rm_mem", 1'b1, pk(3'd3, 16'd40, 4'b0010, 1'b0, 1'b0, 15, 15));
    rst = 1'b0;
    idle_in();
    wb_en_req = 1'b1;
    pc_next   = 16'h0010;
    cyc("rm_rst", 1'b1, pk(3'd3, 16'd40, 4'b0000, 1'b0, 1'b0, 15, 15));
    cyc("rm_rst_next", 1'b1, pk(3'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 0, 0));
    rst = 1'b1;
    idle_in();
    cyc("rm_release", 1'b1, pk(3'd0, 16'h0000, 4'b1000, 1'b0, 1'b0, 0, 0));

    // drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
